// File: rtl/frame_packer_pkg.sv
// Shared definitions for the frame packer and the host-link receiver model:
// FSM state encodings and the default header word.
package frame_packer_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_SUM  = 2'd3;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/frame_checksum.sv
// Running modulo-2^WIDTH checksum of a frame's data words; exposes the negated
// total including the word currently being added, ready to be sent as trailer.
module frame_checksum #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             add,
    input  logic [WIDTH-1:0] word,
    output logic [WIDTH-1:0] neg_next
);

    logic [WIDTH-1:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else if (clr) begin
            sum_q <= '0;
        end else if (add) begin
            sum_q <= sum_q + word;
        end
    end

    // Trailer is computed on the last data beat, so fold that word in here.
    assign neg_next = WIDTH'(0) - (sum_q + word);

endmodule

// File: rtl/frame_packer.sv
// Snapshots a LENGTH-word parallel window on i_start and streams it as
// SYNC header, data words (highest index first), two's-complement checksum.
module frame_packer
    import frame_packer_pkg::*;
#(
    parameter int         WIDTH  = 8,
    parameter int         LENGTH = 4,
    parameter logic [7:0] SYNC   = SYNC_DEFAULT
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [WIDTH*LENGTH-1:0] i_par,
    input  logic                    i_start,
    input  logic                    i_ready,
    output logic [WIDTH-1:0]        o_data,
    output logic                    o_valid,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_drop
);

    localparam int               IDX_W    = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LENGTH - 1);
    localparam logic [WIDTH-1:0] SYNC_W   = WIDTH'(SYNC);

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_dec;
    logic [WIDTH-1:0] snap [LENGTH];
    logic             beat;
    logic             take_start;
    logic             add_word;
    logic [WIDTH-1:0] sum_neg_next;

    assign beat       = o_valid & i_ready;
    // A start is only honoured when the packer is idle or is finishing a frame.
    assign take_start = i_start & ((state == ST_IDLE) | ((state == ST_SUM) & beat));
    assign add_word   = beat & (state == ST_DATA);
    assign idx_dec    = idx - 1'b1;
    assign o_busy     = (state != ST_IDLE);

    frame_checksum #(
        .WIDTH (WIDTH)
    ) u_checksum (
        .clk      (i_clk),
        .rst      (i_rst),
        .clr      (take_start),
        .add      (add_word),
        .word     (o_data),
        .neg_next (sum_neg_next)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
            o_done  <= 1'b0;
            o_drop  <= 1'b0;
            for (int k = 0; k < LENGTH; k++) begin
                snap[k] <= '0;
            end
        end else begin
            o_done <= (state == ST_SUM) & beat;
            o_drop <= i_start & ~take_start;

            if (take_start) begin
                for (int k = 0; k < LENGTH; k++) begin
                    snap[k] <= i_par[k*WIDTH +: WIDTH];
                end
            end

            case (state)
                ST_IDLE: begin
                    if (take_start) begin
                        state   <= ST_HDR;
                        o_valid <= 1'b1;
                        o_data  <= SYNC_W;
                    end
                end
                ST_HDR: begin
                    if (beat) begin
                        state  <= ST_DATA;
                        idx    <= IDX_LAST;
                        o_data <= snap[IDX_LAST];
                    end
                end
                ST_DATA: begin
                    if (beat) begin
                        if (idx == '0) begin
                            state  <= ST_SUM;
                            o_data <= sum_neg_next;
                        end else begin
                            idx    <= idx_dec;
                            o_data <= snap[idx_dec];
                        end
                    end
                end
                ST_SUM: begin
                    if (beat) begin
                        if (take_start) begin
                            state  <= ST_HDR;
                            o_data <= SYNC_W;
                        end else begin
                            state   <= ST_IDLE;
                            o_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_packer.sv
// Directed and randomized bench for frame_packer (WIDTH=8, LENGTH=4, SYNC=A5)
// against a word-list model of the framing rules.
module tb_frame_packer;

    logic        i_clk;
    logic        i_rst;
    logic [31:0] i_par;
    logic        i_start;
    logic        i_ready;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        o_busy;
    logic        o_done;
    logic        o_drop;

    frame_packer #(
        .WIDTH  (8),
        .LENGTH (4),
        .SYNC   (8'hA5)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_par   (i_par),
        .i_start (i_start),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_drop  (o_drop)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int         errors;
    int         checks;
    int         cyc_n;
    logic [7:0] beats [$];
    int         beat_cyc [$];
    logic [7:0] exp_q [$];
    int         done_cnt;
    int         done_cyc;
    int         drop_cnt;
    logic       prev_stall;
    logic [7:0] prev_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference frame: header, words 3..0, then whatever makes data+checksum == 0 mod 256.
    task automatic model_push(input logic [31:0] par);
        int total;
        total = 0;
        exp_q.push_back(8'hA5);
        for (int k = 3; k >= 0; k--) begin
            exp_q.push_back(par[k*8 +: 8]);
            total += int'(par[k*8 +: 8]);
        end
        exp_q.push_back(8'((256 - (total % 256)) % 256));
    endtask

    task automatic sample();
        if (!i_rst) begin
            if (prev_stall) begin
                check("hold_valid", {31'd0, o_valid}, 32'd1);
                check("hold_data", {24'd0, o_data}, {24'd0, prev_data});
            end
            if (o_valid && i_ready) begin
                beats.push_back(o_data);
                beat_cyc.push_back(cyc_n);
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc_n;
            end
            if (o_drop) drop_cnt++;
            prev_stall = o_valid && !i_ready;
            prev_data  = o_data;
        end
    endtask

    task automatic cyc();
        @(negedge i_clk);
        sample();
        @(posedge i_clk);
        cyc_n++;
        #1;
    endtask

    task automatic clear_obs();
        beats.delete();
        beat_cyc.delete();
        exp_q.delete();
        done_cnt = 0;
        drop_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic set_ready(input int mode);
        case (mode)
            0:       i_ready = 1'b1;
            1:       i_ready = ~i_ready;
            default: i_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic compare_frames(input string tag);
        logic [7:0] got;
        check({tag, "_len"}, beats.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < beats.size()) ? beats[i] : 8'hxx;
            check($sformatf("%s_w%0d", tag, i), {24'd0, got}, {24'd0, exp_q[i]});
        end
    endtask

    task automatic run_frame(input logic [31:0] par, input logic [31:0] par_after,
                             input int mode, input string tag, output int start_cyc);
        clear_obs();
        model_push(par);
        i_par     = par;
        i_start   = 1'b1;
        start_cyc = cyc_n;
        set_ready(mode);
        cyc();
        i_start = 1'b0;
        i_par   = par_after;
        for (int k = 0; k < 60 && done_cnt == 0; k++) begin
            set_ready(mode);
            cyc();
        end
        check({tag, "_done"}, done_cnt, 1);
        compare_frames(tag);
    endtask

    initial begin
        int         sc;
        int         s;
        logic [31:0] rp;
        logic       sent_drop;
        logic       sent_b2b;

        errors     = 0;
        checks     = 0;
        cyc_n      = 0;
        prev_stall = 1'b0;
        prev_data  = 8'd0;
        i_rst      = 1'b1;
        i_par      = 32'h0;
        i_start    = 1'b0;
        i_ready    = 1'b0;
        clear_obs();
        #1;
        repeat (2) cyc();
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_data", {24'd0, o_data}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_drop", {31'd0, o_drop}, 32'd0);
        i_rst = 1'b0;
        cyc();

        // Basic frame, ready held high
        run_frame(32'h11121314, 32'h11121314, 0, "t1", sc);
        check("t1_first_lat", beat_cyc.size() > 0 ? beat_cyc[0] : -1, sc + 1);
        for (int i = 1; i < beat_cyc.size(); i++)
            check($sformatf("t1_gap%0d", i), beat_cyc[i], beat_cyc[i-1] + 1);
        check("t1_done_lat", done_cyc, beat_cyc.size() > 0 ? beat_cyc[beat_cyc.size()-1] + 1 : -2);
        check("t1_busy_after", {31'd0, o_busy}, 32'd0);
        check("t1_drop", drop_cnt, 0);

        // Ready toggling each cycle
        i_ready = 1'b0;
        run_frame(32'h11121314, 32'h11121314, 1, "t2", sc);
        check("t2_drop", drop_cnt, 0);

        // Start during DATA is dropped; start with SUM beat chains the next frame
        clear_obs();
        model_push(32'h11121314);
        model_push(32'hFF000001);
        sent_drop = 1'b0;
        sent_b2b  = 1'b0;
        i_ready   = 1'b1;
        i_par     = 32'h11121314;
        i_start   = 1'b1;
        cyc();
        for (int k = 0; k < 60 && done_cnt < 2; k++) begin
            i_start = 1'b0;
            if (beats.size() == 2 && !sent_drop) begin
                i_start   = 1'b1;
                i_par     = 32'hDEADBEEF;
                sent_drop = 1'b1;
            end else if (beats.size() == 5 && !sent_b2b) begin
                i_start  = 1'b1;
                i_par    = 32'hFF000001;
                sent_b2b = 1'b1;
            end
            cyc();
        end
        i_start = 1'b0;
        check("t3_done_cnt", done_cnt, 2);
        check("t3_drop_cnt", drop_cnt, 1);
        compare_frames("t3");
        check("t3_b2b_gap", beat_cyc.size() > 6 ? beat_cyc[6] : -1,
              beat_cyc.size() > 6 ? beat_cyc[5] + 1 : 0);

        // Input change after capture has no effect
        run_frame(32'h11121314, 32'h00000000, 0, "t4", sc);

        // Reset mid-frame while stalled in DATA
        clear_obs();
        i_par   = 32'h11121314;
        i_ready = 1'b1;
        i_start = 1'b1;
        cyc();
        i_start = 1'b0;
        cyc();
        i_ready = 1'b0;
        cyc();
        cyc();
        check("t5_pre_valid", {31'd0, o_valid}, 32'd1);
        check("t5_pre_busy", {31'd0, o_busy}, 32'd1);
        i_rst = 1'b1;
        #1;
        check("t5_rst_valid", {31'd0, o_valid}, 32'd0);
        check("t5_rst_busy", {31'd0, o_busy}, 32'd0);
        check("t5_rst_data", {24'd0, o_data}, 32'd0);
        prev_stall = 1'b0;
        cyc();
        cyc();
        i_rst = 1'b0;
        cyc();
        check("t5_no_done", done_cnt, 0);
        run_frame(32'h11121314, 32'h11121314, 0, "t5", sc);

        // Randomized frames with random back-pressure
        for (int f = 0; f < 200; f++) begin
            rp = $urandom;
            run_frame(rp, $urandom, 2, $sformatf("r%0d", f), sc);
            s = 0;
            for (int i = 1; i < 6 && i < beats.size(); i++) s += int'(beats[i]);
            check($sformatf("r%0d_sum", f), s % 256, 0);
            i_ready = 1'b0;
            repeat ($urandom_range(0, 2)) cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
